// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_state_t;

    // Only the burst kinds the payload requester actually issues are served.
    function automatic logic burst_legal(input logic [2:0] burst);
        return (burst == HBURST_SINGLE) || (burst == HBURST_INCR) || (burst == HBURST_INCR4);
    endfunction

endpackage

// File: rtl/ahb_payload_responder_if.sv
// AHB-Lite bus bundle between the requester (master) and this responder (slave).
interface ahb_payload_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RESP_W = 2
) ();
    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic              hnonsec;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic              hreadyout;
    logic [RESP_W-1:0] hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
               hnonsec, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
               hnonsec, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_word_ram.sv
// Word-addressed register memory: synchronous write, combinational read,
// every word cleared while rst_n is low.
module ahb_word_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] words [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
        logic [WIDTH-1:0] word_reg;

        // Each word loads only when the shared write index selects it.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (we && (widx == IDX_W'(gi))) begin
                word_reg <= wdata;
            end
        end

        assign words[gi] = word_reg;
    end

    assign rdata = words[ridx];
endmodule

// File: rtl/ahb_payload_responder.sv
// AHB-Lite subordinate with a small scratch-pad memory, programmable OKAY
// wait states and two-cycle ERROR responses for transfers it cannot serve.
module ahb_payload_responder
    import ahb_pkg::*;
#(
    parameter int          pAHB_ADDR_WIDTH  = 32,
    parameter int          pAHB_DATA_WIDTH  = 32,
    parameter int          pAHB_HRESP_WIDTH = 2,
    parameter int          pMEM_DEPTH_WORDS = 16,
    parameter logic [31:0] pBASE_ADDR       = 32'h0,
    parameter int          pWAIT_STATES     = 0,
    parameter int          pREJECT_NONSEC   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ahb_payload_responder_if.slave  bus,
    output logic [7:0]              O_err_count
);
    localparam int IDX_W = $clog2(pMEM_DEPTH_WORDS);
    localparam logic [pAHB_ADDR_WIDTH-1:0] BASE = pAHB_ADDR_WIDTH'(pBASE_ADDR);
    localparam logic [pAHB_ADDR_WIDTH-1:0] SPAN = pAHB_ADDR_WIDTH'(4 * pMEM_DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(pWAIT_STATES);

    ahb_state_t         state_reg;
    logic [3:0]         wait_cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               write_reg;
    logic [7:0]         err_count_reg;

    logic [pAHB_ADDR_WIDTH-1:0] addr_offset;
    logic                       ready_phase;
    logic                       accept;
    logic                       legal;
    logic                       ram_we;
    logic [pAHB_DATA_WIDTH-1:0] ram_rdata;
    logic                       unused_inputs;

    // Modular subtraction: an address below BASE wraps to a huge offset, so a
    // single compare against SPAN covers both ends of the window.
    assign addr_offset = bus.haddr - BASE;
    assign ready_phase = (state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2);
    assign accept      = bus.hsel && bus.hready && bus.htrans[1] && ready_phase;
    assign legal       = (bus.hsize == HSIZE_WORD)
                      && (bus.haddr[1:0] == 2'b00)
                      && (addr_offset < SPAN)
                      && burst_legal(bus.hburst)
                      && !((pREJECT_NONSEC != 0) && bus.hnonsec);

    assign unused_inputs = ^{bus.hprot, bus.hmastlock, bus.htrans[0]};

    // Transfer FSM: latches the address phase, runs wait/error sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            idx_reg       <= '0;
            write_reg     <= 1'b0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    if (wait_cnt_reg == 4'd1) begin
                        state_reg <= ST_DATA;
                    end
                end
                ST_ERR1: begin
                    state_reg <= ST_ERR2;
                end
                default: begin
                    if (accept) begin
                        idx_reg   <= addr_offset[IDX_W+1:2];
                        write_reg <= bus.hwrite;
                        if (!legal) begin
                            state_reg <= ST_ERR1;
                            if (err_count_reg != 8'hFF) begin
                                err_count_reg <= err_count_reg + 8'd1;
                            end
                        end else if (WAIT_LOAD != 4'd0) begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Bus handshake outputs are a pure decode of the registered state.
    always_comb begin
        bus.hreadyout = 1'b1;
        bus.hresp     = HRESP_OKAY;
        case (state_reg)
            ST_WAIT: bus.hreadyout = 1'b0;
            ST_ERR1: begin
                bus.hreadyout = 1'b0;
                bus.hresp     = HRESP_ERROR;
            end
            ST_ERR2: bus.hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // The write commits on the edge leaving the final OKAY cycle, which lets
    // an immediately following read of the same word see the new value.
    assign ram_we = (state_reg == ST_DATA) && write_reg;

    ahb_word_ram #(
        .DEPTH (pMEM_DEPTH_WORDS),
        .WIDTH (pAHB_DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .widx  (idx_reg),
        .wdata (bus.hwdata),
        .ridx  (idx_reg),
        .rdata (ram_rdata)
    );

    assign bus.hrdata  = ((state_reg == ST_DATA) && !write_reg) ? ram_rdata : '0;
    assign O_err_count = err_count_reg;
endmodule

// File: tb/tb_ahb_payload_responder.sv
// Directed bench: one responder with zero wait states, one with two.
module tb_ahb_payload_responder;
    import ahb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_payload_responder_if bus0 ();
    ahb_payload_responder_if bus2 ();
    assign bus0.hready = bus0.hreadyout;
    assign bus2.hready = bus2.hreadyout;

    logic [7:0] err0;
    logic [7:0] err2;

    ahb_payload_responder #(.pWAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0), .O_err_count(err0)
    );
    ahb_payload_responder #(.pWAIT_STATES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .O_err_count(err2)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] words [4] = '{32'h31c30019, 32'h67d4acf1, 32'hbcb25768, 32'h708627ae};

    task automatic drive0(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size, input logic [2:0] burst,
                          input logic nonsec);
        bus0.hsel = sel; bus0.htrans = trans; bus0.haddr = addr; bus0.hwrite = wr;
        bus0.hsize = size; bus0.hburst = burst; bus0.hnonsec = nonsec;
        bus0.hprot = 4'h3; bus0.hmastlock = 1'b0;
    endtask

    task automatic drive2(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                          input logic wr, input logic [2:0] size, input logic [2:0] burst,
                          input logic nonsec);
        bus2.hsel = sel; bus2.htrans = trans; bus2.haddr = addr; bus2.hwrite = wr;
        bus2.hsize = size; bus2.hburst = burst; bus2.hnonsec = nonsec;
        bus2.hprot = 4'h3; bus2.hmastlock = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        drive2(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        bus0.hwdata = '0;
        bus2.hwdata = '0;
        repeat (10) @(posedge clk);
        #1;
        tests_run++;
        if ({bus0.hreadyout, bus0.hresp, bus0.hrdata, err0} !== {1'b1, 2'b00, 32'h0, 8'h0}) begin
            tests_failed++;
            $display("FAIL reset_dut0: got rdy=%b resp=%b rdata=%h err=%0d, want 1/00/0/0",
                     bus0.hreadyout, bus0.hresp, bus0.hrdata, err0);
        end
        tests_run++;
        if ({bus2.hreadyout, bus2.hresp, bus2.hrdata, err2} !== {1'b1, 2'b00, 32'h0, 8'h0}) begin
            tests_failed++;
            $display("FAIL reset_dut2: got rdy=%b resp=%b rdata=%h err=%0d, want 1/00/0/0",
                     bus2.hreadyout, bus2.hresp, bus2.hrdata, err2);
        end
        rst_n = 1'b1;
        $display("[TB] reset done");
    endtask

    task automatic test_incr4_write();
        drive0(1'b1, HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD, HBURST_INCR4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if ({bus0.hreadyout, bus0.hresp} !== 3'b100) begin
                tests_failed++;
                $display("FAIL incr4_wr_beat%0d: got rdy=%b resp=%b, want 1/00",
                         i, bus0.hreadyout, bus0.hresp);
            end
            bus0.hwdata = words[i];
            if (i < 3)
                drive0(1'b1, HTRANS_SEQ, 32'h10 + 32'(4 * (i + 1)), 1'b1, HSIZE_WORD, HBURST_INCR4, 1'b0);
            else
                drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
            $display("[TB] incr4 write beat %0d data %h", i, words[i]);
        end
        @(posedge clk);
        #1;
        bus0.hwdata = '0;
    endtask

    task automatic test_incr4_read();
        drive0(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, HBURST_INCR4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3)
                drive0(1'b1, HTRANS_SEQ, 32'h10 + 32'(4 * (i + 1)), 1'b0, HSIZE_WORD, HBURST_INCR4, 1'b0);
            else
                drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
            tests_run++;
            if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {1'b1, 2'b00, words[i]}) begin
                tests_failed++;
                $display("FAIL incr4_rd_beat%0d: got rdy=%b resp=%b rdata=%h, want 1/00/%h",
                         i, bus0.hreadyout, bus0.hresp, bus0.hrdata, words[i]);
            end
            $display("[TB] incr4 read beat %0d data %h", i, bus0.hrdata);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus0.hrdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL incr4_rd_idle: got rdata=%h, want 0", bus0.hrdata);
        end
    endtask

    task automatic test_wait_states();
        drive2(1'b1, HTRANS_NONSEQ, 32'h4, 1'b1, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        bus2.hwdata = 32'hdeadbeef;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 0)
                drive2(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
            tests_run++;
            if ({bus2.hreadyout, bus2.hresp} !== {(c == 2), 2'b00}) begin
                tests_failed++;
                $display("FAIL wait_wr_cycle%0d: got rdy=%b resp=%b, want %b/00",
                         c, bus2.hreadyout, bus2.hresp, (c == 2));
            end
        end
        $display("[TB] wait-state write 0x4 data deadbeef");
        drive2(1'b1, HTRANS_NONSEQ, 32'h4, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 0)
                drive2(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
            tests_run++;
            if ({bus2.hreadyout, bus2.hresp, bus2.hrdata} !==
                {(c == 2), 2'b00, (c == 2) ? 32'hdeadbeef : 32'h0}) begin
                tests_failed++;
                $display("FAIL wait_rd_cycle%0d: got rdy=%b resp=%b rdata=%h",
                         c, bus2.hreadyout, bus2.hresp, bus2.hrdata);
            end
        end
        $display("[TB] wait-state read 0x4 data %h", bus2.hrdata);
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        logic [31:0] e_addr   [3] = '{32'h40, 32'h0, 32'h0};
        logic [2:0]  e_size   [3] = '{HSIZE_WORD, 3'b000, HSIZE_WORD};
        logic        e_nonsec [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0]  base;
        for (int k = 0; k < 3; k++) begin
            base = err0;
            drive0(1'b1, HTRANS_NONSEQ, e_addr[k], 1'b1, e_size[k], HBURST_SINGLE, e_nonsec[k]);
            bus0.hwdata = 32'hbad0bad0;
            @(posedge clk);
            #1;
            drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
            tests_run++;
            if ({bus0.hreadyout, bus0.hresp} !== {1'b0, HRESP_ERROR}) begin
                tests_failed++;
                $display("FAIL err%0d_first: got rdy=%b resp=%b, want 0/01", k, bus0.hreadyout, bus0.hresp);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if ({bus0.hreadyout, bus0.hresp, err0} !== {1'b1, HRESP_ERROR, 8'(base + 8'd1)}) begin
                tests_failed++;
                $display("FAIL err%0d_second: got rdy=%b resp=%b cnt=%0d, want 1/01/%0d",
                         k, bus0.hreadyout, bus0.hresp, err0, base + 8'd1);
            end
            $display("[TB] error transfer %0d addr %h count %0d", k, e_addr[k], err0);
            if (k == 2) begin
                // Requester did not cancel: a transfer presented in the second
                // ERROR cycle must be served normally.
                drive0(1'b1, HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
                @(posedge clk);
                #1;
                drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
                tests_run++;
                if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {1'b1, 2'b00, words[0]}) begin
                    tests_failed++;
                    $display("FAIL err_then_read: got rdy=%b resp=%b rdata=%h, want 1/00/%h",
                             bus0.hreadyout, bus0.hresp, bus0.hrdata, words[0]);
                end
            end
            @(posedge clk);
            #1;
            tests_run++;
            if ({bus0.hreadyout, bus0.hresp} !== 3'b100) begin
                tests_failed++;
                $display("FAIL err%0d_after: got rdy=%b resp=%b, want 1/00", k, bus0.hreadyout, bus0.hresp);
            end
        end
        drive0(1'b1, HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        @(posedge clk);
        #1;
        drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        tests_run++;
        if (bus0.hrdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL err_mem_unchanged: got word0=%h, want 0", bus0.hrdata);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        drive0(1'b1, HTRANS_NONSEQ, 32'h8, 1'b1, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        @(posedge clk);
        #1;
        bus0.hwdata = 32'h11111111;
        drive0(1'b1, HTRANS_NONSEQ, 32'h8, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        tests_run++;
        if ({bus0.hreadyout, bus0.hresp} !== 3'b100) begin
            tests_failed++;
            $display("FAIL b2b_wr_data: got rdy=%b resp=%b, want 1/00", bus0.hreadyout, bus0.hresp);
        end
        @(posedge clk);
        #1;
        drive0(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        tests_run++;
        if ({bus0.hreadyout, bus0.hresp, bus0.hrdata} !== {1'b1, 2'b00, 32'h11111111}) begin
            tests_failed++;
            $display("FAIL b2b_rd: got rdy=%b resp=%b rdata=%h, want 1/00/11111111",
                     bus0.hreadyout, bus0.hresp, bus0.hrdata);
        end
        $display("[TB] back-to-back write/read 0x8 data %h", bus0.hrdata);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_wait();
        drive2(1'b1, HTRANS_NONSEQ, 32'hC, 1'b1, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        bus2.hwdata = 32'hcafef00d;
        @(posedge clk);
        #1;
        drive2(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        tests_run++;
        if ({bus2.hreadyout, bus2.hresp} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rmw_in_wait: got rdy=%b resp=%b, want 0/00", bus2.hreadyout, bus2.hresp);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus2.hreadyout, bus2.hresp, bus2.hrdata} !== {1'b1, 2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL rmw_reset_outputs: got rdy=%b resp=%b rdata=%h, want 1/00/0",
                     bus2.hreadyout, bus2.hresp, bus2.hrdata);
        end
        tests_run++;
        if (err0 !== 8'h0) begin
            tests_failed++;
            $display("FAIL rmw_errcnt_cleared: got %0d, want 0", err0);
        end
        rst_n = 1'b1;
        drive2(1'b1, HTRANS_NONSEQ, 32'hC, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        @(posedge clk);
        #1;
        drive2(1'b0, HTRANS_IDLE, 32'h0, 1'b0, HSIZE_WORD, HBURST_SINGLE, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus2.hreadyout, bus2.hresp, bus2.hrdata} !== {1'b1, 2'b00, 32'h0}) begin
            tests_failed++;
            $display("FAIL rmw_read_zero: got rdy=%b resp=%b rdata=%h, want 1/00/0",
                     bus2.hreadyout, bus2.hresp, bus2.hrdata);
        end
        $display("[TB] reset mid-wait, read 0xC data %h", bus2.hrdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_incr4_write();
        test_incr4_read();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
